oam_dma_arbiter: RTL and testbench

Sits between the CPU core's memory port and the shared memory/mapped-register bus. Passes CPU accesses straight through when idle. A CPU write to the DMA trigger register takes ownership of the bus and copies 256 bytes from page {data,8'h00} to the OAM data port, stalling the CPU via cpu_rdy. It is the only master-select point for the memory bus.

---
 rtl/oam_dma_arbiter_pkg.sv | 16 +
 rtl/oam_dma_arbiter.sv | 95 +++++++++
 tb/tb_oam_dma_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_arbiter_pkg.sv
// Shared constants for the OAM DMA arbiter: bus widths, fixed addresses and FSM encodings.
package oam_dma_arbiter_pkg;

  localparam int REG_WIDTH      = 8;
  localparam int ADDR_WIDTH_DEF = 16;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

  localparam logic [2:0] DMA_IDLE  = 3'd0;
  localparam logic [2:0] DMA_HALT  = 3'd1;
  localparam logic [2:0] DMA_ALIGN = 3'd2;
  localparam logic [2:0] DMA_READ  = 3'd3;
  localparam logic [2:0] DMA_WRITE = 3'd4;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Memory bus master select: CPU pass-through when idle, 256-byte page copy to the OAM data port on trigger.
//
// state | meaning
// IDLE  | CPU owns the bus, combinational pass-through
// HALT  | CPU stalled, bus idle for one cycle
// ALIGN | extra idle cycle so every READ lands on cyc_odd=1
// READ  | fetch byte {page,idx}
// WRITE | store fetched byte to the OAM data port
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter int               WIDTH         = REG_WIDTH,
  parameter int               ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0]      cpu_din,
  input  logic                  cpu_we,
  output logic [WIDTH-1:0]      cpu_dout,
  output logic                  cpu_rdy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_din,
  output logic                  mem_we,
  input  logic [WIDTH-1:0]      mem_dout,
  output logic                  dma_active
);

  logic [2:0]       state, state_nxt;
  logic [7:0]       page;
  logic [7:0]       idx;
  logic [WIDTH-1:0] data;
  logic             cyc_odd;
  logic             hit;

  assign hit = cpu_we && (cpu_addr == DMA_REG_ADDR);

  always_comb begin
    state_nxt = state;
    case (state)
      DMA_IDLE:  if (hit) state_nxt = DMA_HALT;
      DMA_HALT:  state_nxt = cyc_odd ? DMA_ALIGN : DMA_READ;
      DMA_ALIGN: state_nxt = DMA_READ;
      DMA_READ:  state_nxt = DMA_WRITE;
      DMA_WRITE: state_nxt = (idx == 8'hFF) ? DMA_IDLE : DMA_READ;
      default:   state_nxt = DMA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= DMA_IDLE;
      page    <= 8'h00;
      idx     <= 8'h00;
      data    <= '0;
      cyc_odd <= 1'b0;
    end else begin
      state   <= state_nxt;
      cyc_odd <= ~cyc_odd;
      case (state)
        DMA_IDLE: if (hit) begin
          page <= cpu_din[7:0];
          idx  <= 8'h00;
        end
        DMA_READ:  data <= mem_dout;
        DMA_WRITE: idx  <= idx + 8'h01;
        default: ;
      endcase
    end
  end

  // Busy states ignore every cpu_* input; only IDLE lets the CPU reach the bus.
  always_comb begin
    mem_addr = cpu_addr;
    mem_din  = cpu_din;
    mem_we   = 1'b0;
    case (state)
      DMA_IDLE:  mem_we = cpu_we & ~hit;
      DMA_READ:  mem_addr = ADDR_WIDTH'({page, idx});
      DMA_WRITE: begin
        mem_addr = OAM_DATA_ADDR;
        mem_din  = data;
        mem_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_rdy    = (state == DMA_IDLE);
  assign dma_active = (state != DMA_IDLE);
  assign cpu_dout   = mem_dout;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: byte memory model, OAM capture queue, vector table and DMA sequences.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic [7:0]  cpu_dout;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic        dma_active;

  oam_dma_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_we     (cpu_we),
    .cpu_dout   (cpu_dout),
    .cpu_rdy    (cpu_rdy),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  logic [7:0] cap [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         bad_4014 = 0;
  int         odd_viol = 0;
  logic       tb_odd;
  logic [7:0] cur_page = 8'h00;

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr == 16'h2004) cap.push_back(mem_din);
      else mem[mem_addr] <= mem_din;
      if (mem_addr == 16'h4014) bad_4014++;
    end
  end

  // Reference parity: counts clocks since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_odd <= 1'b0;
    else tb_odd <= ~tb_odd;
  end

  always @(negedge clk) begin
    #2;
    if (reset_n && dma_active && !mem_we && mem_addr[15:8] == cur_page && cur_page != 8'h00
        && mem_addr != cpu_addr && tb_odd !== 1'b1)
      odd_viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  din;
    logic        we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_din;
    logic        exp_we;
    logic        chk_dout;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs[6];

  task automatic run_dma(input logic [7:0] pg, input logic want_odd, input logic poke,
                         input int exp_stall, input string tag);
    int stall;
    int act_bad;
    bit done;
    int k;
    cap.delete();
    bad_4014 = 0;
    odd_viol = 0;
    cur_page = pg;
    k = 0;
    @(negedge clk);
    while (tb_odd !== want_odd && k < 4) begin
      @(negedge clk);
      k++;
    end
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_din = pg;
    #1;
    chk({tag, " trig mem_we"}, mem_we, 1'b0);
    chk({tag, " trig rdy"}, cpu_rdy, 1'b1);
    stall = 0; act_bad = 0; done = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      if (poke && dma_active) begin
        cpu_we = 1'b1;
        cpu_addr = c[0] ? 16'h0010 : 16'h4014;
        cpu_din  = c[0] ? 8'hFF : 8'h03;
      end else begin
        cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_din = 8'h00;
      end
      #1;
      if (!cpu_rdy) begin
        stall++;
        if (dma_active !== 1'b1) act_bad++;
      end else done = 1;
    end
    chk({tag, " completed"}, done, 1'b1);
    chk({tag, " stall cycles"}, stall, exp_stall);
    chk({tag, " dma_active while busy"}, act_bad, 0);
    chk({tag, " oam write count"}, cap.size(), 256);
    chk({tag, " writes to 4014"}, bad_4014, 0);
    chk({tag, " read on even cycle"}, odd_viol, 0);
    chk({tag, " dma_active after"}, dma_active, 1'b0);
  endtask

  initial begin
    int data_bad;
    int k;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      mem[16'hFF00 + i] = 8'(i) ^ 8'hC3;
    end

    vecs[0] = '{16'h0010, 8'hA5, 1'b1, 16'h0010, 8'hA5, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{16'h0011, 8'h3C, 1'b1, 16'h0011, 8'h3C, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{16'h0010, 8'h00, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{16'h0011, 8'h00, 1'b0, 16'h0011, 8'h00, 1'b0, 1'b1, 8'h3C};
    vecs[4] = '{16'h4014, 8'h55, 1'b0, 16'h4014, 8'h55, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{16'h4015, 8'h66, 1'b1, 16'h4015, 8'h66, 1'b1, 1'b0, 8'h00};

    reset_n = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_din = 8'h11;
    #1;
    chk("reset rdy", cpu_rdy, 1'b1);
    chk("reset dma_active", dma_active, 1'b0);
    chk("reset mem_we", mem_we, 1'b1);
    cpu_addr = 16'h4014;
    #1;
    chk("reset hit mem_we", mem_we, 1'b0);
    cpu_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      cpu_addr = vecs[i].addr; cpu_din = vecs[i].din; cpu_we = vecs[i].we;
      #1;
      chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d mem_din", i), mem_din, vecs[i].exp_din);
      chk($sformatf("vec%0d mem_we", i), mem_we, vecs[i].exp_we);
      chk($sformatf("vec%0d cpu_rdy", i), cpu_rdy, 1'b1);
      chk($sformatf("vec%0d dma_active", i), dma_active, 1'b0);
      if (vecs[i].chk_dout) chk($sformatf("vec%0d cpu_dout", i), cpu_dout, vecs[i].exp_dout);
    end
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 16'h0000;

    // Trigger posedge with tb_odd=1 puts HALT on an even cycle: no ALIGN.
    run_dma(8'h02, 1'b1, 1'b0, 513, "even");
    data_bad = 0;
    for (int i = 0; i < 256 && i < cap.size(); i++) if (cap[i] !== (8'(i) ^ 8'h5A)) data_bad++;
    chk("even data", data_bad, 0);

    run_dma(8'h02, 1'b0, 1'b1, 514, "odd busy");
    data_bad = 0;
    for (int i = 0; i < 256 && i < cap.size(); i++) if (cap[i] !== (8'(i) ^ 8'h5A)) data_bad++;
    chk("odd busy data", data_bad, 0);
    chk("busy 0010 untouched", mem[16'h0010], 8'hA5);

    run_dma(8'hFF, 1'b1, 1'b0, 513, "top page");
    data_bad = 0;
    for (int i = 0; i < 256 && i < cap.size(); i++) if (cap[i] !== (8'(i) ^ 8'hC3)) data_bad++;
    chk("top page data", data_bad, 0);

    // Second top-page copy confirms idx restarted at 00 after wrap.
    run_dma(8'hFF, 1'b0, 1'b0, 514, "top again");
    chk("top again first byte", cap.size() > 0 ? cap[0] : 8'hXX, 8'hC3);

    cap.delete();
    cur_page = 8'h02;
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_din = 8'h02;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 16'h0000;
    k = 0;
    while (cap.size() < 100 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("midop reached 100", cap.size(), 100);
    reset_n = 1'b0;
    cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_din = 8'h77;
    #1;
    chk("midop dma_active", dma_active, 1'b0);
    chk("midop rdy", cpu_rdy, 1'b1);
    chk("midop mem_we", mem_we, 1'b1);
    chk("midop mem_addr", mem_addr, 16'h0030);
    @(negedge clk);
    cpu_we = 1'b0;
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midop captured", cap.size(), 100);
    chk("midop idle", dma_active, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
